// File: rtl/dcache_bus_ctrl_if.sv
// Bus-side bundle of the data-cache controller: cache miss/victim/snoop-lookup
// inputs, memory/coherence bus handshake, and fill / tag-update results.
`default_nettype none

interface dcache_bus_ctrl_if #(
    parameter int WORD_W = 32
);
    logic              miss_req;
    logic [WORD_W-1:0] miss_addr;
    logic              miss_excl;
    logic              vic_dirty;
    logic [WORD_W-1:0] vic_addr;
    logic [WORD_W-1:0] vic_data0;
    logic [WORD_W-1:0] vic_data1;
    logic [1:0]        snp_state;
    logic [WORD_W-1:0] snp_data0;
    logic [WORD_W-1:0] snp_data1;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    logic              ccwait;
    logic              ccinv;
    logic [WORD_W-1:0] ccsnoopaddr;

    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              ccwrite;
    logic              cctrans;
    logic              fill_we;
    logic              fill_sel;
    logic [WORD_W-1:0] fill_data;
    logic              miss_done;
    logic [1:0]        fill_state;
    logic              snp_upd;
    logic [1:0]        snp_new;

    modport master (
        input  miss_req, miss_addr, miss_excl, vic_dirty, vic_addr, vic_data0, vic_data1,
        input  snp_state, snp_data0, snp_data1, dwait, dload, ccwait, ccinv, ccsnoopaddr,
        output dREN, dWEN, daddr, dstore, ccwrite, cctrans, fill_we, fill_sel, fill_data,
        output miss_done, fill_state, snp_upd, snp_new
    );

    modport slave (
        output miss_req, miss_addr, miss_excl, vic_dirty, vic_addr, vic_data0, vic_data1,
        output snp_state, snp_data0, snp_data1, dwait, dload, ccwait, ccinv, ccsnoopaddr,
        input  dREN, dWEN, daddr, dstore, ccwrite, cctrans, fill_we, fill_sel, fill_data,
        input  miss_done, fill_state, snp_upd, snp_new
    );
endinterface

`default_nettype wire

// File: rtl/dcache_bus_ctrl.sv
// Data-cache bus controller: two-word writeback/fill sequencing for misses and
// MSI snoop response with cache-to-cache supply of modified lines.
`default_nettype none

module dcache_bus_ctrl #(
    parameter int WORD_W  = 32,
    parameter int BLK_OFF = 3
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    dcache_bus_ctrl_if.master bus
);
    localparam logic [1:0]        ST_I      = 2'd0;
    localparam logic [1:0]        ST_S      = 2'd1;
    localparam logic [1:0]        ST_M      = 2'd2;
    localparam logic [WORD_W-1:0] WORD_STEP = WORD_W'(4);
    localparam logic [WORD_W-1:0] BLK_MASK  = ~(WORD_W'((1 << BLK_OFF) - 1));

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WB0  = 3'd1,
        WB1  = 3'd2,
        RD0  = 3'd3,
        RD1  = 3'd4,
        SNP  = 3'd5,
        SWB0 = 3'd6,
        SWB1 = 3'd7
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WORD_W-1:0] miss_blk;
    logic [WORD_W-1:0] snp_blk;

    assign miss_blk = bus.miss_addr & BLK_MASK;
    assign snp_blk  = bus.ccsnoopaddr & BLK_MASK;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        bus.dREN       = 1'b0;
        bus.dWEN       = 1'b0;
        bus.daddr      = '0;
        bus.dstore     = '0;
        bus.ccwrite    = 1'b0;
        bus.cctrans    = 1'b0;
        bus.fill_we    = 1'b0;
        bus.fill_sel   = 1'b0;
        bus.fill_data  = '0;
        bus.miss_done  = 1'b0;
        bus.fill_state = ST_I;
        bus.snp_upd    = 1'b0;
        bus.snp_new    = ST_I;

        case (state)
            IDLE: begin
                // Snoops take precedence so the bus owner is never stalled by us.
                if (bus.ccwait) begin
                    next_state = SNP;
                end else if (bus.miss_req && bus.vic_dirty) begin
                    next_state = WB0;
                end else if (bus.miss_req) begin
                    next_state = RD0;
                end
            end

            WB0, WB1: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = (state == WB1) ? bus.vic_addr + WORD_STEP : bus.vic_addr;
                bus.dstore = (state == WB1) ? bus.vic_data1 : bus.vic_data0;
                if (!bus.dwait) begin
                    if (state == WB0) begin
                        next_state = WB1;
                    end else begin
                        next_state  = RD0;
                        bus.cctrans = 1'b1;
                    end
                end
            end

            RD0, RD1: begin
                bus.dREN    = 1'b1;
                bus.daddr   = (state == RD1) ? miss_blk + WORD_STEP : miss_blk;
                bus.ccwrite = bus.miss_excl;
                if (!bus.dwait) begin
                    bus.fill_we   = 1'b1;
                    bus.fill_sel  = (state == RD1);
                    bus.fill_data = bus.dload;
                    if (state == RD0) begin
                        next_state = RD1;
                    end else begin
                        next_state     = IDLE;
                        bus.miss_done  = 1'b1;
                        bus.fill_state = bus.miss_excl ? ST_M : ST_S;
                        bus.cctrans    = 1'b1;
                    end
                end
            end

            SNP: begin
                if (bus.snp_state == ST_M) begin
                    next_state = SWB0;
                end else if (!bus.ccwait) begin
                    next_state = IDLE;
                    if (bus.snp_state == ST_S && bus.ccinv) begin
                        bus.snp_upd = 1'b1;
                        bus.snp_new = ST_I;
                        bus.cctrans = 1'b1;
                    end
                end
            end

            SWB0, SWB1: begin
                bus.dWEN    = 1'b1;
                bus.ccwrite = 1'b1;
                bus.daddr   = (state == SWB1) ? snp_blk + WORD_STEP : snp_blk;
                bus.dstore  = (state == SWB1) ? bus.snp_data1 : bus.snp_data0;
                if (!bus.dwait) begin
                    if (state == SWB0) begin
                        next_state = SWB1;
                    end else begin
                        next_state  = IDLE;
                        bus.snp_upd = 1'b1;
                        bus.snp_new = bus.ccinv ? ST_I : ST_S;
                        bus.cctrans = 1'b1;
                    end
                end
            end

            default: next_state = IDLE;
        endcase
    end
endmodule

`default_nettype wire

// File: tb/tb_dcache_bus_ctrl.sv
// Self-checking bench for dcache_bus_ctrl: transaction-level expectation queue
// plus event counters, driven by directed and randomized miss/snoop traffic.
`timescale 1ns/1ps
`default_nettype none

module tb_dcache_bus_ctrl;
    localparam int W = 32;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    dcache_bus_ctrl_if #(.WORD_W(W)) bus ();

    dcache_bus_ctrl #(.WORD_W(W), .BLK_OFF(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        bit          ccw;
        bit          sel;
    } xfer_t;

    xfer_t       exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          upd_cnt = 0;
    int          trans_cnt = 0;
    int          fill_cnt = 0;
    logic [1:0]  exp_fill_state = 2'd0;
    logic [1:0]  exp_snp_new = 2'd0;
    bit          stall_mode = 1'b0;
    int          stall_at = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus model: random wait states and read data; optional stall after a given fill.
    initial begin
        bus.dwait = 1'b1;
        bus.dload = '0;
        forever begin
            @(posedge CLK);
            #1;
            bus.dload = $urandom;
            if (stall_mode && fill_cnt >= stall_at) bus.dwait = 1'b1;
            else                                   bus.dwait = ($urandom % 2) != 0;
        end
    end

    // Monitor: every completed bus beat must match the next expected transfer.
    always @(negedge CLK) begin
        if (!RST) begin
            chk("rd_wr_overlap", {31'd0, bus.dREN & bus.dWEN}, 32'd0);
            if (!bus.dWEN) chk("dstore_idle", bus.dstore, 32'd0);
            chk("fill_we", {31'd0, bus.fill_we}, {31'd0, bus.dREN & ~bus.dwait});
            if ((bus.dREN || bus.dWEN) && !bus.dwait) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", exp_q.size(), 32'd1);
                end else begin
                    xfer_t x;
                    x = exp_q.pop_front();
                    chk("xfer_dir", {31'd0, bus.dWEN}, {31'd0, x.wr});
                    chk("daddr", bus.daddr, x.addr);
                    chk("ccwrite", {31'd0, bus.ccwrite}, {31'd0, x.ccw});
                    if (x.wr) begin
                        chk("dstore", bus.dstore, x.data);
                    end else begin
                        chk("fill_sel", {31'd0, bus.fill_sel}, {31'd0, x.sel});
                        chk("fill_data", bus.fill_data, bus.dload);
                        fill_cnt++;
                    end
                end
            end
            if (bus.miss_done) begin
                done_cnt++;
                chk("fill_state", {30'd0, bus.fill_state}, {30'd0, exp_fill_state});
            end
            if (bus.snp_upd) begin
                upd_cnt++;
                chk("snp_new", {30'd0, bus.snp_new}, {30'd0, exp_snp_new});
            end
            if (bus.cctrans) trans_cnt++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1, input bit ccw);
        exp_q.push_back('{wr: 1'b1, addr: a,      data: d0, ccw: ccw, sel: 1'b0});
        exp_q.push_back('{wr: 1'b1, addr: a + 4,  data: d1, ccw: ccw, sel: 1'b1});
    endtask

    task automatic push_rd(input logic [31:0] a, input bit ccw);
        logic [31:0] base;
        base = a & ~32'h7;
        exp_q.push_back('{wr: 1'b0, addr: base,     data: 32'd0, ccw: ccw, sel: 1'b0});
        exp_q.push_back('{wr: 1'b0, addr: base + 4, data: 32'd0, ccw: ccw, sel: 1'b1});
    endtask

    // Runs the bus until the targets are met; plays the requester/bus roles of
    // dropping miss_req after miss_done and ccwait after the snoop update.
    task automatic wait_for(input int nd, input int nu);
        int i;
        i = 0;
        while ((done_cnt < nd || upd_cnt < nu || exp_q.size() != 0) && i < 400) begin
            tick();
            i++;
            if (bus.ccwait && upd_cnt >= nu) bus.ccwait = 1'b0;
            if (bus.miss_req && done_cnt >= nd) bus.miss_req = 1'b0;
        end
        chk("timeout", {31'd0, i < 400}, 32'd1);
        exp_q.delete();
        bus.ccwait   = 1'b0;
        bus.miss_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {24'd0, bus.dREN, bus.dWEN, bus.ccwrite, bus.cctrans,
                            bus.fill_we, bus.fill_sel, bus.miss_done, bus.snp_upd}, 32'd0);
        chk({tag, "_daddr"}, bus.daddr, 32'd0);
        chk({tag, "_dstore"}, bus.dstore, 32'd0);
        chk({tag, "_fill_data"}, bus.fill_data, 32'd0);
        chk({tag, "_states"}, {28'd0, bus.fill_state, bus.snp_new}, 32'd0);
    endtask

    task automatic do_miss(input logic [31:0] a, input bit excl, input bit dirty,
                           input logic [31:0] va, input logic [31:0] v0, input logic [31:0] v1);
        int d0, t0, u0;
        d0 = done_cnt; t0 = trans_cnt; u0 = upd_cnt;
        if (dirty) push_wr(va, v0, v1, 1'b0);
        push_rd(a, excl);
        exp_fill_state = excl ? 2'd2 : 2'd1;
        bus.miss_addr = a; bus.miss_excl = excl; bus.vic_dirty = dirty;
        bus.vic_addr = va; bus.vic_data0 = v0; bus.vic_data1 = v1;
        bus.miss_req = 1'b1;
        wait_for(d0 + 1, u0);
        chk("miss_done_cnt", done_cnt - d0, 32'd1);
        chk("cctrans_miss", trans_cnt - t0, dirty ? 32'd2 : 32'd1);
        chk("snp_upd_on_miss", upd_cnt - u0, 32'd0);
    endtask

    task automatic do_snoop(input logic [31:0] a, input logic [1:0] st, input bit inv,
                            input logic [31:0] s0, input logic [31:0] s1);
        int t0, u0;
        bit upd_exp;
        t0 = trans_cnt; u0 = upd_cnt;
        bus.ccsnoopaddr = a; bus.snp_state = st; bus.ccinv = inv;
        bus.snp_data0 = s0; bus.snp_data1 = s1;
        if (st == 2'd2) begin
            push_wr(a & ~32'h7, s0, s1, 1'b1);
            exp_snp_new = inv ? 2'd0 : 2'd1;
            bus.ccwait = 1'b1;
            wait_for(done_cnt, u0 + 1);
            upd_exp = 1'b1;
        end else begin
            exp_snp_new = 2'd0;
            bus.ccwait = 1'b1;
            repeat (1 + $urandom % 3) tick();
            bus.ccwait = 1'b0;
            tick();
            tick();
            upd_exp = (st == 2'd1) && inv;
        end
        chk("snp_upd_cnt", upd_cnt - u0, {31'd0, upd_exp});
        chk("cctrans_snp", trans_cnt - t0, {31'd0, upd_exp});
        bus.snp_state = 2'd0; bus.ccinv = 1'b0;
    endtask

    initial begin
        int d0, t0, u0;
        bus.miss_req = 0; bus.miss_addr = 0; bus.miss_excl = 0; bus.vic_dirty = 0;
        bus.vic_addr = 0; bus.vic_data0 = 0; bus.vic_data1 = 0;
        bus.snp_state = 0; bus.snp_data0 = 0; bus.snp_data1 = 0;
        bus.ccwait = 0; bus.ccinv = 0; bus.ccsnoopaddr = 0;

        repeat (3) tick();
        @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b0;
        tick();

        do_miss(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        do_miss(32'h308, 1'b1, 1'b1, 32'h200, 32'hAAAA, 32'hBBBB);
        do_snoop(32'h40, 2'd2, 1'b1, 32'h1111_0000, 32'h2222_0000);
        do_snoop(32'h44, 2'd2, 1'b0, 32'h3333_0000, 32'h4444_0000);
        do_snoop(32'h40, 2'd1, 1'b1, 32'h0, 32'h0);
        do_snoop(32'h40, 2'd1, 1'b0, 32'h0, 32'h0);
        do_snoop(32'h48, 2'd0, 1'b1, 32'h0, 32'h0);

        // Miss and snoop arriving together: snoop transfer first, miss afterwards.
        d0 = done_cnt; u0 = upd_cnt; t0 = trans_cnt;
        push_wr(32'h80, 32'hCAFE_0001, 32'hCAFE_0002, 1'b1);
        push_rd(32'h600, 1'b0);
        exp_snp_new = 2'd0; exp_fill_state = 2'd1;
        bus.ccsnoopaddr = 32'h84; bus.snp_state = 2'd2; bus.ccinv = 1'b1;
        bus.snp_data0 = 32'hCAFE_0001; bus.snp_data1 = 32'hCAFE_0002;
        bus.miss_addr = 32'h600; bus.miss_excl = 1'b0; bus.vic_dirty = 1'b0;
        bus.miss_req = 1'b1; bus.ccwait = 1'b1;
        wait_for(d0 + 1, u0 + 1);
        chk("race_done", done_cnt - d0, 32'd1);
        chk("race_upd", upd_cnt - u0, 32'd1);
        chk("race_cctrans", trans_cnt - t0, 32'd2);
        bus.snp_state = 2'd0; bus.ccinv = 1'b0;

        // Reset while RD1 is stalled: no completion, outputs cleared.
        stall_at = fill_cnt + 1;
        stall_mode = 1'b1;
        exp_q.push_back('{wr: 1'b0, addr: 32'h500, data: 32'd0, ccw: 1'b0, sel: 1'b0});
        exp_fill_state = 2'd1;
        bus.miss_addr = 32'h504; bus.miss_excl = 1'b0; bus.vic_dirty = 1'b0;
        bus.miss_req = 1'b1;
        for (int i = 0; i < 200 && fill_cnt < stall_at; i++) tick();
        chk("stall_fill_reached", {31'd0, fill_cnt >= stall_at}, 32'd1);
        tick();
        tick();
        chk("stall_in_rd1", {31'd0, bus.dREN}, 32'd1);
        d0 = done_cnt; t0 = trans_cnt;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        bus.miss_req = 1'b0;
        stall_mode = 1'b0;
        @(negedge CLK);
        check_all_zero("rst_mid");
        chk("rst_no_done", done_cnt - d0, 32'd0);
        chk("rst_no_cctrans", trans_cnt - t0, 32'd0);
        exp_q.delete();
        tick();
        do_miss(32'h504, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);

        for (int n = 0; n < 24; n++) begin
            if ($urandom % 2 == 0) begin
                do_miss($urandom & 32'hFFFF_FFFC, ($urandom % 2) != 0, ($urandom % 2) != 0,
                        $urandom & 32'hFFFF_FFF8, $urandom, $urandom);
            end else begin
                do_snoop($urandom & 32'hFFFF_FFFC, 2'($urandom % 3), ($urandom % 2) != 0,
                         $urandom, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire

// File: doc/dcache_bus_ctrl.md
Name: dcache_bus_ctrl

Overview:
- Per-core data-cache bus-side controller. Sits directly upstream of the coherency controller, one instance per core.
- Turns cache misses into two-word block writebacks and fills on the dREN/dWEN/daddr/dstore bus, with MSI intent signalled on ccwrite/cctrans.
- Acts as snoop responder: answers ccwait/ccsnoopaddr/ccinv with a cache-to-cache supply when its line is M, and produces line-state updates for the tag array.

Parameters:
- WORD_W, 32, data/address width.
- BLK_OFF, 3, byte-offset bits per block (2 words); block address = addr with bits [BLK_OFF-1:0] cleared.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- miss_req  in  1  cache requests a block; held until miss_done
- miss_addr  in  WORD_W  missing address
- miss_excl  in  1  1 = store miss (needs M), 0 = load miss (S)
- vic_dirty  in  1  victim line is M and must be written back first
- vic_addr  in  WORD_W  victim block address
- vic_data0, vic_data1  in  WORD_W  victim words
- snp_state  in  2  tag-array lookup of ccsnoopaddr, same cycle: 0=I, 1=S, 2=M
- snp_data0, snp_data1  in  WORD_W  data of the snooped line
- dwait  in  1  bus wait for this core
- dload  in  WORD_W  bus read data
- ccwait  in  1  bus is snooping this core
- ccinv  in  1  snoop requires invalidate
- ccsnoopaddr  in  WORD_W  snooped address
- dREN, dWEN  out  1  bus read/write request
- daddr, dstore  out  WORD_W  bus address, write data
- ccwrite  out  1  own miss: exclusive intent; snoop: supplying data
- cctrans  out  1  one-cycle pulse on any own-line MSI transition
- fill_we  out  1  write fill_data into word fill_sel of the miss line
- fill_sel  out  1  word index
- fill_data  out  WORD_W  fill word
- miss_done  out  1  one-cycle pulse; line installed with state fill_state
- fill_state  out  2  1=S, 2=M
- snp_upd  out  1  one-cycle pulse: write snp_new into the snooped line's tag
- snp_new  out  2  new state for the snooped line

Behaviour:
- Reset: state IDLE; all outputs 0.
- States: IDLE, WB0, WB1, RD0, RD1, SNP, SWB0, SWB1.
- IDLE priority:
  - ccwait → SNP. Snoop wins even if miss_req is high the same cycle.
  - else miss_req & vic_dirty → WB0.
  - else miss_req → RD0.
- WB0/WB1: dWEN=1, daddr = vic_addr + 0/4, dstore = vic_data0/1, ccwrite=0.
  - Advance on dwait=0: WB0→WB1→RD0.
  - cctrans pulses on WB1 exit (victim M→I).
- RD0/RD1: dREN=1, daddr = blk(miss_addr) + 0/4, ccwrite = miss_excl.
  - On dwait=0: fill_we=1, fill_sel=0/1, fill_data=dload.
  - RD1 completion: miss_done=1, fill_state = miss_excl ? M : S, cctrans=1, → IDLE.
  - miss_req is ignored once RD0 is entered; a drop mid-fill is a protocol violation and the fill still completes.
- SNP (entered with ccwait=1):
  - snp_state=M → SWB0, dWEN=1, ccwrite=1.
  - else dWEN=0, ccwrite=0, held while ccwait=1. On exit, if snp_state=S and ccinv=1: snp_upd=1, snp_new=I, cctrans=1. Then → IDLE.
- SWB0/SWB1: dWEN=1, ccwrite=1, daddr = blk(ccsnoopaddr) + 0/4, dstore = snp_data0/1.
  - Advance on dwait=0.
  - SWB1 exit: snp_upd=1, snp_new = ccinv ? I : S, cctrans=1, → IDLE.
- Write-data rule: dstore is valid whenever dWEN=1; it is 0 otherwise.
- Simultaneous dREN and dWEN never occur.
- ccwait arriving outside IDLE/SNP is ignored. The bus grants only one core at a time, so this cannot occur legally.
- RST mid-transfer: back to IDLE next edge, all outputs 0, no partial fill reported.

Test Plan:
- Clean load miss at 0x100, miss_excl=0, dwait low after 2 cycles per word → daddr 0x100 then 0x104, fill_we twice, miss_done with fill_state=1, cctrans pulse.
- Dirty store miss: vic_addr=0x200, vic_data 0xAAAA/0xBBBB, miss_addr=0x308 → writes 0x200/0x204, then reads 0x308/0x30C (block base 0x308) with ccwrite=1; fill_state=2.
- Snoop hit M with ccinv=1 at 0x40 → dWEN=ccwrite=1, dstore=snp_data0 at 0x40 then snp_data1 at 0x44; snp_upd with snp_new=0.
- Snoop hit M with ccinv=0 → same transfer, snp_new=1. Snoop hit S with ccinv=1 → no dWEN, snp_new=0. Snoop miss (I) → no snp_upd.
- miss_req and ccwait rise in the same cycle → SNP first; miss serviced after ccwait drops, no lost request.
- RST asserted in RD1 with dwait high → next cycle all outputs 0, no miss_done; new miss afterwards completes normally.
